// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: opcode constants, instruction-format and loader state enums shared by the MIPS front end.
package mips_isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILLEGAL} fmt_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
  function automatic fmt_e op_format(input logic [5:0] op);
    return (op == OP_RTYPE) ? FMT_R :
           (op inside {OP_J, OP_JAL}) ? FMT_J :
           (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW}) ? FMT_I :
           FMT_ILLEGAL;
  endfunction
endpackage

// File: rtl/instr_field_encoder.sv
// instr_field_encoder: packs instruction fields into an R/I/J word and reports the selected format.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output fmt_e        fmt_o
);
  logic [4:0] rs_eff;
  always_comb begin
    fmt_o  = op_format(op_i);
    rs_eff = (op_i == OP_LUI) ? 5'd0 : rs_i;
    word_o = (fmt_o == FMT_R) ? {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i} :
             (fmt_o == FMT_J) ? {op_i, target_i} :
             (fmt_o == FMT_I) ? {op_i, rs_eff, rt_i, imm_i} : 32'd0;
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction field bundles, encodes them and writes them
// to consecutive instruction-memory word addresses.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [5:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   word_count
);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  err_q;
  logic                  full_q;
  logic [31:0]           word;
  fmt_e                  fmt;

  instr_field_encoder u_enc (
    .op_i     (in_op),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (word),
    .fmt_o    (fmt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state_q != S_LOAD && start) begin
        state_q <= S_LOAD;
        addr_q  <= ADDR_WIDTH'(BASE_ADDR);
        cnt_q   <= '0;
        err_q   <= 1'b0;
        full_q  <= 1'b0;
      end else if (state_q == S_LOAD && in_valid) begin
        if (fmt == FMT_ILLEGAL) begin
          err_q <= 1'b1;
          if (in_last) state_q <= S_DONE;
        end else begin
          we_q    <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= word;
          cnt_q   <= cnt_q + 1'b1;
          // the top address ends the session instead of wrapping the counter
          if (&addr_q) begin
            state_q <= S_DONE;
            full_q  <= ~in_last;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (in_last) state_q <= S_DONE;
          end
        end
      end
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD);
  assign done        = (state_q == S_DONE);
  assign mem_we      = we_q;
  assign mem_addr    = waddr_q;
  assign mem_wdata   = wdata_q;
  assign err_illegal = err_q;
  assign full        = full_q;
  assign word_count  = cnt_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus random bundles on an 8-bit and a 2-bit address instance,
// checked each cycle against a behavioural model and a captured memory image.
module tb_instr_encoder_loader;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [5:0] in_op = '0, in_funct = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic o_ready[2], o_we[2], o_busy[2], o_done[2], o_err[2], o_full[2];
  logic [31:0] o_wd[2];
  logic [7:0] o_addr0;
  logic [1:0] o_addr1;
  logic [8:0] o_wc0;
  logic [2:0] o_wc1;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(o_ready[0]),
    .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(o_we[0]), .mem_addr(o_addr0), .mem_wdata(o_wd[0]), .busy(o_busy[0]),
    .done(o_done[0]), .err_illegal(o_err[0]), .full(o_full[0]), .word_count(o_wc0));

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(o_ready[1]),
    .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(o_we[1]), .mem_addr(o_addr1), .mem_wdata(o_wd[1]), .busy(o_busy[1]),
    .done(o_done[1]), .err_illegal(o_err[1]), .full(o_full[1]), .word_count(o_wc1));

  // behavioural model: session flags, next address, count, registered write, memory image
  bit m_busy[2], m_done[2], m_err[2], m_full[2], m_we[2];
  int m_addr[2], m_cnt[2], m_waddr[2];
  bit [31:0] m_wdata[2];
  bit [31:0] ref_mem[2][256];
  bit [31:0] cap_mem[2][256];

  function automatic int cap_of(int i);
    return i == 0 ? 256 : 4;
  endfunction

  function automatic bit legal(bit [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic bit [31:0] enc(bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                                    bit [4:0] sh, bit [5:0] fn, bit [15:0] imm, bit [25:0] tg);
    int unsigned w;
    w = 32'(op) << 26;
    if (op == 6'h00) w = w + (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + (32'(sh) << 6) + 32'(fn);
    else if (op == 6'h02 || op == 6'h03) w = w + 32'(tg);
    else w = w + ((op == 6'h0f) ? 0 : (32'(rs) << 21)) + (32'(rt) << 16) + 32'(imm);
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_full[i] = 0; m_we[i] = 0;
        m_addr[i] = 0; m_cnt[i] = 0; m_waddr[i] = 0; m_wdata[i] = 0;
      end else begin
        if (m_we[i]) ref_mem[i][m_waddr[i]] = m_wdata[i];
        m_we[i] = 0;
        if (!m_busy[i] && start) begin
          m_busy[i] = 1; m_done[i] = 0; m_addr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 0;
        end else if (m_busy[i] && in_valid) begin
          if (!legal(in_op)) begin
            m_err[i] = 1;
            if (in_last) begin m_busy[i] = 0; m_done[i] = 1; end
          end else begin
            m_we[i] = 1; m_waddr[i] = m_addr[i];
            m_wdata[i] = enc(in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
            m_cnt[i]++;
            if (m_addr[i] == cap_of(i) - 1) begin
              m_busy[i] = 0; m_done[i] = 1; m_full[i] = !in_last;
            end else begin
              m_addr[i]++;
              if (in_last) begin m_busy[i] = 0; m_done[i] = 1; end
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (o_we[0]) cap_mem[0][o_addr0] = o_wd[0];
    if (o_we[1]) cap_mem[1][o_addr1] = o_wd[1];
  end

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready%0d", i), 32'(o_ready[i]), 32'(m_busy[i]));
      chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_busy[i]));
      chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(m_done[i]));
      chk($sformatf("err%0d", i), 32'(o_err[i]), 32'(m_err[i]));
      chk($sformatf("full%0d", i), 32'(o_full[i]), 32'(m_full[i]));
      chk($sformatf("we%0d", i), 32'(o_we[i]), 32'(m_we[i]));
      chk($sformatf("wdata%0d", i), o_wd[i], m_wdata[i]);
      chk($sformatf("addr%0d", i), i == 0 ? 32'(o_addr0) : 32'(o_addr1), 32'(m_waddr[i]));
      chk($sformatf("wc%0d", i), i == 0 ? 32'(o_wc0) : 32'(o_wc1), 32'(m_cnt[i]));
    end
  endtask

  task automatic cmp_mem();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < cap_of(i); a++)
        chk($sformatf("mem%0d[%0d]", i, a), cap_mem[i][a], ref_mem[i][a]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic put(bit l, bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                     bit [4:0] sh, bit [5:0] fn, bit [15:0] imm, bit [25:0] tg);
    in_valid = 1; in_last = l; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tg;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic put_rand(bit l);
    bit [5:0] ops[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    bit [5:0] op;
    op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
    put(l, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
        16'($urandom), 26'($urandom));
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    reset = 1;
    #1;
    check_all();
    chk("rst_ready", 32'(o_ready[0]), 0);
    chk("rst_wdata", o_wd[0], 0);
    tick();
    reset = 0;
    tick();
    // start together with a valid bundle in IDLE: only the start is taken
    start = 1; in_valid = 1; in_op = 6'h08;
    tick();
    start = 0; in_valid = 0;
    chk("start_nowrite", 32'(o_we[0]), 0);
    put(1, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0);
    chk("r_wdata", o_wd[0], 32'h012A4020);
    chk("r_addr", 32'(o_addr0), 0);
    chk("r_wc", 32'(o_wc0), 1);
    tick();
    chk("r_we_pulse", 32'(o_we[0]), 0);
    do_start();
    put(0, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'd5, 26'h0);
    chk("addi", o_wd[0], 32'h20080005);
    put(0, 6'h0f, 5'd3, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1001, 26'h0);
    chk("lui", o_wd[0], 32'h3C011001);
    chk("lui_addr", 32'(o_addr0), 1);
    put(1, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100003);
    chk("jal", o_wd[0], 32'h0C100003);
    chk("jal_done", 32'(o_done[0]), 1);
    tick();
    do_start();
    put(0, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h10, 26'h0);
    put(0, 6'h3f, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
    chk("illegal_nowe", 32'(o_we[0]), 0);
    put(1, 6'h2b, 5'd4, 5'd6, 5'd0, 5'd0, 6'h0, 16'h14, 26'h0);
    chk("illegal_err", 32'(o_err[0]), 1);
    chk("illegal_addr", 32'(o_addr0), 1);
    chk("illegal_wc", 32'(o_wc0), 2);
    tick();
    cmp_mem();
    // capacity: the 2-bit instance fills after four writes, dut0 keeps loading
    do_start();
    for (int k = 0; k < 5; k++) put(0, 6'h0d, 5'(k), 5'(k + 1), 5'd0, 5'd0, 6'h0, 16'(k), 26'h0);
    chk("full1", 32'(o_full[1]), 1);
    chk("full1_wc", 32'(o_wc1), 4);
    chk("full1_ready", 32'(o_ready[1]), 0);
    // start during LOAD is ignored by dut0 but restarts the DONE dut1
    start = 1;
    put(0, 6'h04, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'hfffe, 26'h0);
    start = 0;
    chk("start_in_load_addr", 32'(o_addr0), 5);
    chk("restart_full_clr", 32'(o_full[1]), 0);
    put(0, 6'h05, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0);
    chk("mid_we", 32'(o_we[0]), 1);
    // asynchronous reset while a write is being presented
    reset = 1;
    #1;
    check_all();
    chk("async_we", 32'(o_we[0]), 0);
    tick();
    reset = 0;
    tick();
    do_start();
    put(1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3ffffff);
    chk("reload_addr", 32'(o_addr0), 0);
    chk("reload_wc", 32'(o_wc0), 1);
    tick();
    cmp_mem();
    for (int s = 0; s < 12; s++) begin
      int len;
      len = $urandom_range(1, 14);
      do_start();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) tick();
        start = ($urandom_range(0, 7) == 0);
        put_rand(k == len - 1);
        start = 0;
      end
      tick();
      cmp_mem();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
